line_encoder: RTL and testbench
===============================

Name: line_encoder

Overview:
Parametrised serial line encoder, the successor to the single-mode NRZI encoder. It accepts parallel words over a valid/ready handshake and serialises them at a programmable bit period. Each word is line-coded as NRZ, NRZI or Manchester. It sits between the frame/test-pattern source and the output pin driver of the line-coding playground.

Parameters:
DATA_W, 8, word width in bits (≥2).
CLKS_PER_BIT, 4, clk cycles per bit period; must be even and ≥2 (Manchester uses CLKS_PER_BIT/2 per half).
IDLE_LEVEL, 1'b1, line level when idle and after reset.
LSB_FIRST, 1, 1 sends in_data[0] first; 0 sends in_data[DATA_W-1] first.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous, active-high reset.
mode  in  2  00 NRZ, 01 NRZI, 10 Manchester, 11 reserved (treated as NRZ); sampled only at handshake.
in_data  in  DATA_W  word to transmit.
in_valid  in  1  in_data/mode valid.
in_ready  out  1  encoder can accept a word this cycle.
line_out  out  1  encoded serial line (registered).
line_oe  out  1  high while a bit period (data or stuff) is being driven.
busy  out  1  high from handshake until the last bit period completes.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; line_out=IDLE_LEVEL; line_oe=0; busy=0; in_ready=0 while rst is high. Any in-flight word is dropped without completing.
- States: IDLE, SHIFT.
- in_ready=1 in IDLE, and also in SHIFT during the final cycle of the final bit period. This allows back-to-back words with no gap.
- Handshake = in_valid & in_ready at posedge. At that same edge:
  - word and mode are latched;
  - bit index, period counter and half-flag are cleared;
  - line_out takes the first bit's (first half's) level;
  - line_oe=1, busy=1;
  - state=SHIFT.
- Period counter runs 0..CLKS_PER_BIT-1. Each bit holds exactly CLKS_PER_BIT cycles. A word is DATA_W periods, plus any stuff bits.
- Encoding per bit b:
  - NRZ: line=b.
  - NRZI: b=0 inverts the previous line level; b=1 holds it. The reference level is the current line_out, carried across words and idle.
  - Manchester (IEEE 802.3): first half line=~b, second half line=b. The mid-bit edge occurs at counter==CLKS_PER_BIT/2.
- After the final period with no new handshake: state=IDLE, line_oe=0, busy=0.
  - NRZ/Manchester: line_out returns to IDLE_LEVEL.
  - NRZI: line_out holds its last level.
- Back-to-back handshake in the final cycle: the next word's first bit starts on the next edge. line_oe and busy stay 1.
- Changes to mode or in_data after the handshake have no effect on the current word.
- The period counter wraps to 0 only at the bit boundary. The bit index never exceeds DATA_W-1.

Optional Feature:
LINE_ENCODER_BIT_STUFF_EN
- Defined: after 6 consecutive transmitted data 1s, one stuffed 0 bit period is inserted before the next data bit. It is encoded in the current mode and consumes no data.
  - The ones-run counter spans back-to-back words and clears on a 0, on a stuff bit, on entry to IDLE, and on rst.
  - A stuff bit due after the last data bit is still sent before in_ready asserts.
- Undefined: no stuffing logic is present; frame length is always DATA_W periods.

Decomposition:
- Package line_code_pkg:
  - mode encoding constants (MODE_NRZ, MODE_NRZI, MODE_MANCH, MODE_RSVD);
  - state enum (ST_IDLE, ST_SHIFT);
  - stuff-run limit constant STUFF_RUN=6.
- Sub-module line_bit_timer: CLKS_PER_BIT period counter with a start/clear input. It outputs bit_end (last cycle of the period) and mid (counter==CLKS_PER_BIT/2).

Test Plan:
- Reset: assert rst for 3 cycles mid-word -> line_out=1, line_oe=0, busy=0, in_ready=0 during rst and 1 the cycle after.
- NRZI, defaults, in_data=8'h0F -> line levels per 4-cycle period 1,1,1,1,0,1,0,1. Line holds 1 afterwards; busy high for 32 cycles.
- Manchester, in_data=8'hA5 -> bits 1,0,1,0,0,1,0,1, each shown as 2 cycles ~b then 2 cycles b. line_out=1 after the frame.
- Back-to-back NRZ: 8'h01 then 8'h80 with in_valid held -> second word accepted in cycle 31. No idle gap; line_oe continuously 1 for 64 cycles.
- NRZ mode toggled to Manchester 5 cycles after handshake -> current word stays NRZ. The next word is Manchester.
- LINE_ENCODER_BIT_STUFF_EN, NRZ, 8'hFF -> sequence 1,1,1,1,1,1,0,1,1 (9 periods, 36 cycles). Without the macro: 8 periods, 32 cycles.

Source files
------------

// File: rtl/line_code_pkg.sv
// Shared line-coding definitions: mode encodings, FSM states, stuffing limit
// and the per-bit level encoder used by line_encoder.
package line_code_pkg;

  localparam logic [1:0] MODE_NRZ   = 2'b00;
  localparam logic [1:0] MODE_NRZI  = 2'b01;
  localparam logic [1:0] MODE_MANCH = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  localparam int STUFF_RUN = 6;
  localparam int RUN_W     = 3;

  // Level at the start of a bit period; prev is the level currently on the line.
  function automatic logic encode_level(input logic b, input logic [1:0] m, input logic prev);
    case (m)
      MODE_NRZI:            return b ? prev : ~prev;
      MODE_MANCH:           return ~b;
      MODE_NRZ, MODE_RSVD:  return b;
      default:              return b;
    endcase
  endfunction

endpackage

// File: rtl/line_bit_timer.sv
// Bit-period counter for line_encoder: counts 0..CLKS_PER_BIT-1 while run is high,
// flags the last cycle of the period, the mid-bit cycle and the cycle before it.
module line_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic bit_end,
  output logic mid,
  output logic half_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_HLAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end  = run && (cnt_q == CNT_LAST);
  assign mid      = run && (cnt_q == CNT_MID);
  assign half_end = run && (cnt_q == CNT_HLAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (start || !run || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/line_encoder.sv
// Serial line encoder (NRZ / NRZI / Manchester) with valid/ready word input.
// Optional zero-bit stuffing after long runs of ones: define LINE_ENCODER_BIT_STUFF_EN.
module line_encoder
  import line_code_pkg::*;
#(
  parameter int   DATA_W       = 8,
  parameter int   CLKS_PER_BIT = 4,
  parameter logic IDLE_LEVEL   = 1'b1,
  parameter bit   LSB_FIRST    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              line_out,
  output logic              line_oe,
  output logic              busy
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        mode_q, mode_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              line_q, line_d;
  logic              half_q, half_d;

  logic bit_end, mid, half_end;
  logic shifting, hs, last, cur_bit;
  logic stuff_q, stuff_due;

  function automatic logic pick(input logic [DATA_W-1:0] w, input logic [IW-1:0] i);
    return LSB_FIRST ? w[i] : w[IDX_LAST - i];
  endfunction

  assign shifting = (state_q == ST_SHIFT);
  assign cur_bit  = stuff_q ? 1'b0 : pick(word_q, idx_q);
  // Final cycle of the frame: last data bit done and no stuff bit still owed.
  assign last     = shifting && bit_end && (idx_q == IDX_LAST) && (stuff_q || !stuff_due);
  assign in_ready = !rst && (!shifting || last);
  assign hs       = in_valid && in_ready;

  assign line_out = line_q;
  assign line_oe  = shifting;
  assign busy     = shifting;

  line_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (hs),
    .run      (shifting),
    .bit_end  (bit_end),
    .mid      (mid),
    .half_end (half_end)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    line_d  = line_q;
    half_d  = half_q;
    if (hs) begin
      word_d  = in_data;
      mode_d  = mode;
      idx_d   = '0;
      half_d  = 1'b0;
      state_d = ST_SHIFT;
      line_d  = encode_level(pick(in_data, '0), mode, line_q);
    end else if (shifting) begin
      if (bit_end) begin
        half_d = 1'b0;
        if (last) begin
          state_d = ST_IDLE;
          // NRZI keeps its reference level across idle; other codes park.
          if (mode_q != MODE_NRZI) line_d = IDLE_LEVEL;
        end else if (stuff_due) begin
          line_d = encode_level(1'b0, mode_q, line_q);
        end else begin
          idx_d  = idx_q + 1'b1;
          line_d = encode_level(pick(word_q, idx_q + 1'b1), mode_q, line_q);
        end
      end else begin
        if (mid) half_d = 1'b1;
        if (half_end && !half_q && mode_q == MODE_MANCH) line_d = cur_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      mode_q  <= MODE_NRZ;
      idx_q   <= '0;
      line_q  <= IDLE_LEVEL;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      half_q  <= half_d;
    end
  end

`ifdef LINE_ENCODER_BIT_STUFF_EN
  logic [RUN_W-1:0] run_q, run_d;
  logic             stuff_d;

  // Stuff period is owed once the current data 1 completes a run of STUFF_RUN.
  assign stuff_due = !stuff_q && cur_bit && (run_q == RUN_W'(STUFF_RUN - 1));

  always_comb begin
    run_d   = run_q;
    stuff_d = stuff_q;
    if (!shifting) begin
      run_d   = '0;
      stuff_d = 1'b0;
    end else if (bit_end) begin
      stuff_d = stuff_due;
      if ((last && !hs) || stuff_q || !cur_bit) run_d = '0;
      else                                      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      stuff_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      stuff_q <= stuff_d;
    end
  end
`else
  assign stuff_q   = 1'b0;
  assign stuff_due = 1'b0;
`endif

endmodule

// File: tb/tb_line_encoder.sv
// Bench for line_encoder: per-cycle comparison against a frame-level model that
// expands each accepted word into its expected line levels.
module tb_line_encoder;
  import line_code_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    mode = 2'b00;
  logic          in_ready, line_out, line_oe, busy;

  always #5 clk = ~clk;

  line_encoder #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .IDLE_LEVEL(1'b1), .LSB_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .line_out (line_out),
    .line_oe  (line_oe),
    .busy     (busy)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         busy_seen = 0;
  bit         exp_q[$];
  bit         idle_line = 1'b1;
  int         run = 0;
  logic [1:0] cur_mode = MODE_NRZ;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expand one word into per-cycle line levels, starting from the current line level.
  function automatic void build(input logic [DW-1:0] d, input logic [1:0] m, input bit ref_lvl);
    bit bits[$];
    bit prev;
    prev = ref_lvl;
    for (int i = 0; i < DW; i++) begin
      bit b;
      b = d[i];
      bits.push_back(b);
`ifdef LINE_ENCODER_BIT_STUFF_EN
      if (b) begin
        run++;
        if (run == STUFF_RUN) begin
          bits.push_back(1'b0);
          run = 0;
        end
      end else run = 0;
`endif
    end
    foreach (bits[k]) begin
      if (m == MODE_NRZI) begin
        if (!bits[k]) prev = ~prev;
        for (int c = 0; c < CPB; c++) exp_q.push_back(prev);
      end else if (m == MODE_MANCH) begin
        for (int c = 0; c < CPB; c++) exp_q.push_back(c < CPB/2 ? ~bits[k] : bits[k]);
      end else begin
        for (int c = 0; c < CPB; c++) exp_q.push_back(bits[k]);
      end
    end
  endfunction

  task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input logic [1:0] m,
                      output bit hs);
    bit cur;
    bit act;
    @(negedge clk);
    act = exp_q.size() > 0;
    chk("line_out", 32'(line_out), 32'(act ? exp_q[0] : idle_line));
    chk("line_oe",  32'(line_oe),  32'(act));
    chk("busy",     32'(busy),     32'(act));
    chk("in_ready", 32'(in_ready), 32'(!rst && exp_q.size() <= 1));
    if (busy === 1'b1) busy_seen++;
    rst = r; in_valid = v; in_data = d; mode = m;
    @(posedge clk);
    cyc++;
    hs = 1'b0;
    if (r) begin
      exp_q.delete();
      idle_line = 1'b1;
      run = 0;
    end else begin
      hs  = v && (exp_q.size() <= 1);
      cur = act ? exp_q[0] : idle_line;
      if (act) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0 && !hs) begin
          idle_line = (cur_mode == MODE_NRZI) ? cur : 1'b1;
          run = 0;
        end
      end
      if (hs) begin
        cur_mode = m;
        build(d, m, cur);
      end
    end
  endtask

  task automatic idle(input int n);
    bit h;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom), 2'($urandom), h);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, output int hs_cyc);
    bit h;
    int k;
    h = 1'b0;
    k = 0;
    while (!h && k < 200) begin
      step(1'b0, 1'b1, d, m, h);
      k++;
    end
    chk("hs_timeout", 32'(h), 32'd1);
    hs_cyc = cyc;
  endtask

  initial begin
    bit h;
    int c1, c2;
    int ff_len;
`ifdef LINE_ENCODER_BIT_STUFF_EN
    ff_len = 9 * CPB;
`else
    ff_len = 8 * CPB;
`endif
    step(1'b1, 1'b0, '0, MODE_NRZ, h);
    step(1'b1, 1'b0, '0, MODE_NRZ, h);
    idle(2);

    send(8'h0F, MODE_NRZI, c1);
    busy_seen = 0;
    idle(40);
    chk("nrzi_busy_len", 32'(busy_seen), 32'(8 * CPB));

    send(8'hA5, MODE_MANCH, c1);
    idle(40);

    send(8'h01, MODE_NRZ, c1);
    send(8'h80, MODE_NRZ, c2);
    chk("b2b_gap", 32'(c2 - c1), 32'(8 * CPB));
    idle(40);

    send(8'h3C, MODE_NRZ, c1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h5A, MODE_MANCH, h);
    send(8'h3C, MODE_MANCH, c1);
    idle(40);

    send(8'hFF, MODE_NRZ, c1);
    busy_seen = 0;
    idle(60);
    chk("ff_busy_len", 32'(busy_seen), 32'(ff_len));

    send(8'hAA, MODE_MANCH, c1);
    idle(10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h55, MODE_NRZ, h);
    idle(5);

    for (int w = 0; w < 300; w++) begin
      int gap;
      logic [DW-1:0] d;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : DW'($urandom);
      send(d, 2'($urandom), c1);
    end
    idle(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
